// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, shift-add multiply and
// restoring divide, with a start/busy/done handshake toward the pipeline controller.
module mul_div_unit #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [OP_W-1:0] OP_MUL    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_MULH   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(2);
    localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t              state, state_next;
    logic [OP_W-1:0]     op_q;
    logic [CNT_W-1:0]    count;
    logic                neg_q;
    logic [DATA_W-1:0]   b_mag;
    // Upper half is the partial product / running remainder, lower half the
    // multiplier / dividend being shifted out.
    logic [2*DATA_W-1:0] acc;

    logic                is_div_in, a_signed_in, b_signed_in, a_neg, b_neg, neg_in;
    logic                div_zero, div_ovf, special;
    logic [DATA_W-1:0]   a_mag_in, b_mag_in, special_res;

    logic [DATA_W:0]     mul_sum, rem_shift, diff;
    logic [2*DATA_W-1:0] acc_step, prod_fix;
    logic [DATA_W-1:0]   quot_fix, rem_fix, final_res;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_div_in   = op[2];
        a_signed_in = is_div_in ? ~op[0] : (op == OP_MULH || op == OP_MULHSU);
        b_signed_in = is_div_in ? ~op[0] : (op == OP_MULH);
        a_neg       = a_signed_in & operand_a[DATA_W-1];
        b_neg       = b_signed_in & operand_b[DATA_W-1];
        a_mag_in    = a_neg ? -operand_a : operand_a;
        b_mag_in    = b_neg ? -operand_b : operand_b;
        neg_in      = (is_div_in && op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero    = is_div_in && (operand_b == '0);
        div_ovf     = is_div_in && !op[0] && (operand_a == INT_MIN) && (operand_b == '1);
        special     = div_zero | div_ovf;
        if (div_zero) special_res = op[1] ? operand_a : '1;
        else          special_res = op[1] ? '0 : operand_a;
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, b_mag} : '0);
        rem_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        diff      = rem_shift - {1'b0, b_mag};
        acc_step  = {mul_sum, acc[DATA_W-1:1]};
        if (op_q[2]) begin
            // A borrow out of the trial subtraction means the divisor did not fit.
            if (diff[DATA_W]) acc_step = {rem_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
            else              acc_step = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
        end

        prod_fix = neg_q ? -acc_step : acc_step;
        quot_fix = neg_q ? -acc_step[DATA_W-1:0] : acc_step[DATA_W-1:0];
        rem_fix  = neg_q ? -acc_step[2*DATA_W-1:DATA_W] : acc_step[2*DATA_W-1:DATA_W];

        if (op_q[2])              final_res = op_q[1] ? rem_fix : quot_fix;
        else if (op_q == OP_MUL)  final_res = prod_fix[DATA_W-1:0];
        else                      final_res = prod_fix[2*DATA_W-1:DATA_W];
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = special ? FIN : CALC;
            CALC: if (count == '0) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // NOTE: sequential state uses non-blocking assignments so all flops update from
    // the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= '0;
            count  <= '0;
            neg_q  <= 1'b0;
            b_mag  <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    op_q  <= op;
                    neg_q <= neg_in;
                    b_mag <= b_mag_in;
                    acc   <= {{DATA_W{1'b0}}, a_mag_in};
                    count <= CNT_W'(DATA_W-1);
                    if (special) result <= special_res;
                end
                CALC: begin
                    acc   <= acc_step;
                    count <= count - 1'b1;
                    // Result is registered on the last iteration so it is valid with done.
                    if (count == '0) result <= final_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: arithmetic results, latency,
// special cases, start handling while busy, and reset abort.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        busy, done;
    logic [31:0] result;

    int n_pass  = 0;
    int n_total = 0;

    mul_div_unit #(.DATA_W(32), .OP_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Call just after an accepting edge; lat=1 is the first cycle after acceptance.
    task automatic wait_done(output int lat, output logic [31:0] res, output logic busy_first);
        lat = -1;
        res = 'x;
        busy_first = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) busy_first = busy;
            if (done) begin
                lat = c;
                res = result;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic busy_first);
        @(negedge clk);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        wait_done(lat, res, busy_first);
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_total++; if (result !== 32'h0) $display("FAIL reset_result got=%h exp=0", result); else n_pass++;
        // start together with reset must be dropped
        start = 1'b1; op = 3'b000; operand_a = 32'd1; operand_b = 32'd1;
        @(posedge clk);
        #1 start = 1'b0; reset = 1'b0;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_start_busy got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_mul;
        int lat; logic [31:0] res; logic b1;
        run_op(3'b000, 32'd7, 32'd6, lat, res, b1);
        n_total++; if (b1 !== 1'b1) $display("FAIL mul_busy_rise got=%b exp=1", b1); else n_pass++;
        n_total++; if (lat !== 33) $display("FAIL mul_latency got=%0d exp=33", lat); else n_pass++;
        n_total++; if (res !== 32'h0000002A) $display("FAIL mul_result got=%h exp=0000002a", res); else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL mul_busy_fall got=%b exp=0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL mul_done_pulse got=%b exp=0", done); else n_pass++;
        n_total++; if (result !== 32'h0000002A) $display("FAIL mul_result_hold got=%h exp=0000002a", result); else n_pass++;
    endtask

    task automatic test_mul_high;
        int lat; logic [31:0] res; logic b1;
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res, b1);
        n_total++; if (res !== 32'h00000000) $display("FAIL mulh got=%h exp=00000000", res); else n_pass++;
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res, b1);
        n_total++; if (res !== 32'hFFFFFFFE) $display("FAIL mulhu got=%h exp=fffffffe", res); else n_pass++;
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res, b1);
        n_total++; if (res !== 32'hFFFFFFFF) $display("FAIL mulhsu got=%h exp=ffffffff", res); else n_pass++;
        n_total++; if (lat !== 33) $display("FAIL mulhsu_latency got=%0d exp=33", lat); else n_pass++;
        run_op(3'b000, 32'hFFFFFFFD, 32'd5, lat, res, b1);
        n_total++; if (res !== 32'hFFFFFFF1) $display("FAIL mul_neg got=%h exp=fffffff1", res); else n_pass++;
    endtask

    task automatic test_div;
        int lat; logic [31:0] res; logic b1;
        run_op(3'b100, 32'hFFFFFFEC, 32'd3, lat, res, b1);
        n_total++; if (res !== 32'hFFFFFFFA) $display("FAIL div got=%h exp=fffffffa", res); else n_pass++;
        n_total++; if (lat !== 33) $display("FAIL div_latency got=%0d exp=33", lat); else n_pass++;
        run_op(3'b110, 32'hFFFFFFEC, 32'd3, lat, res, b1);
        n_total++; if (res !== 32'hFFFFFFFE) $display("FAIL rem got=%h exp=fffffffe", res); else n_pass++;
        run_op(3'b101, 32'd20, 32'd3, lat, res, b1);
        n_total++; if (res !== 32'd6) $display("FAIL divu got=%h exp=00000006", res); else n_pass++;
        run_op(3'b111, 32'd20, 32'd3, lat, res, b1);
        n_total++; if (res !== 32'd2) $display("FAIL remu got=%h exp=00000002", res); else n_pass++;
        run_op(3'b101, 32'hFFFFFFFF, 32'h00000010, lat, res, b1);
        n_total++; if (res !== 32'h0FFFFFFF) $display("FAIL divu_large got=%h exp=0fffffff", res); else n_pass++;
    endtask

    task automatic test_special;
        int lat; logic [31:0] res; logic b1;
        run_op(3'b101, 32'd20, 32'd0, lat, res, b1);
        n_total++; if (lat !== 1) $display("FAIL divu0_latency got=%0d exp=1", lat); else n_pass++;
        n_total++; if (res !== 32'hFFFFFFFF) $display("FAIL divu0 got=%h exp=ffffffff", res); else n_pass++;
        run_op(3'b111, 32'd20, 32'd0, lat, res, b1);
        n_total++; if (res !== 32'd20) $display("FAIL remu0 got=%h exp=00000014", res); else n_pass++;
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, lat, res, b1);
        n_total++; if (lat !== 1) $display("FAIL div_ovf_latency got=%0d exp=1", lat); else n_pass++;
        n_total++; if (res !== 32'h80000000) $display("FAIL div_ovf got=%h exp=80000000", res); else n_pass++;
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, lat, res, b1);
        n_total++; if (res !== 32'h00000000) $display("FAIL rem_ovf got=%h exp=00000000", res); else n_pass++;
    endtask

    task automatic test_start_handling;
        int lat; logic [31:0] res; logic b1;
        @(negedge clk);
        op = 3'b000; operand_a = 32'd1000; operand_b = 32'd1000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        op = 3'b000; operand_a = 32'd2; operand_b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, res, b1);
        n_total++; if (lat + 10 !== 33) $display("FAIL busy_start_latency got=%0d exp=33", lat + 10); else n_pass++;
        n_total++; if (res !== 32'd1000000) $display("FAIL busy_start_result got=%h exp=000f4240", res); else n_pass++;
        // Still in the done cycle: request now, must only be taken one cycle later.
        op = 3'b000; operand_a = 32'd3; operand_b = 32'd4; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL done_cycle_start_busy got=%b exp=0", busy); else n_pass++;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, res, b1);
        n_total++; if (lat !== 33) $display("FAIL reissue_latency got=%0d exp=33", lat); else n_pass++;
        n_total++; if (res !== 32'd12) $display("FAIL reissue_result got=%h exp=0000000c", res); else n_pass++;
    endtask

    task automatic test_reset_abort;
        int lat; logic [31:0] res; logic b1; int seen;
        @(negedge clk);
        op = 3'b100; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL abort_done got=%b exp=0", done); else n_pass++;
        n_total++; if (result !== 32'h0) $display("FAIL abort_result got=%h exp=0", result); else n_pass++;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL abort_no_done got=%0d exp=0", seen); else n_pass++;
        run_op(3'b000, 32'd3, 32'd5, lat, res, b1);
        n_total++; if (lat !== 33) $display("FAIL post_reset_latency got=%0d exp=33", lat); else n_pass++;
        n_total++; if (res !== 32'd15) $display("FAIL post_reset_result got=%h exp=0000000f", res); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_special();
        test_start_handling();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit.
- Sits directly downstream of the register file: consumes rs1/rs2 read data and returns a 32-bit result to the write-back mux.
- Uses a start/busy/done handshake so the controller can stall PC and register write while an M-extension instruction executes.
- One bit per cycle: shift-add for multiply, restoring division for divide.

Parameters:
- DATA_W, 32, operand/result width; the iteration count equals DATA_W.
- OP_W, 3, width of the operation select (funct3).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  OP_W  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  input  DATA_W  rs1 data.
- operand_b  input  DATA_W  rs2 data.
- busy  output  1  high from the cycle after start is accepted until done is asserted, inclusive.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  DATA_W  registered result; held until the next accepted start.

Behaviour:
- Reset (synchronous, active-high):
  - state goes to IDLE; busy=0, done=0, result=0; internal accumulators cleared.
  - Overrides any in-progress operation; no done pulse is produced for an aborted op.
- States: IDLE, CALC, FIN.
- IDLE:
  - start=1 latches op, operand_a and operand_b.
  - Signs are resolved at latch: operands that are signed for the op are converted to magnitude, and the result sign is recorded. MULH treats a and b as signed; MULHSU treats a as signed, b unsigned; DIV/REM treat both as signed.
  - Special cases go directly to FIN with the result preloaded:
    - Divide by zero: DIV/DIVU give all-ones; REM/REMU give operand_a.
    - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - All other ops go to CALC with the counter at DATA_W-1.
- CALC:
  - One iteration per cycle. Multiply is a 2*DATA_W-bit product shift-add. Divide is restoring: shift the remainder in the next dividend bit, subtract the divisor if no borrow, set the quotient bit.
  - Counter decrements each cycle; at 0, go to FIN.
- FIN:
  - Apply sign correction (two's-complement negate of the product, quotient or remainder as recorded).
  - Select the output: MUL gives the low DATA_W bits; MULH/MULHSU/MULHU give the high DATA_W bits; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Register result, pulse done=1 for exactly one cycle, return to IDLE.
  - Remainder sign follows the dividend.
- Latency:
  - Normal op: start accepted at edge N; done high in cycle N+DATA_W+1.
  - Special case: done high in cycle N+1.
- busy is 1 in CALC and FIN, 0 in IDLE.
- start while busy is ignored; operands are not re-latched.
- start in the same cycle done is high is ignored, because the unit is not yet in IDLE. It is accepted on the following cycle.
- Operand inputs may change freely after acceptance; the latched copies are used.
- result holds its value after done until the next accepted start. It is not cleared on return to IDLE.
- reset and start asserted in the same cycle: reset wins and start is dropped.

Test Plan:
1. Reset, then MUL a=7 b=6 with start for one cycle -> busy rises next cycle; done pulses exactly 33 cycles after acceptance with result=42 (0x0000002A); busy falls with done.
2. MULH a=0xFFFFFFFF b=0xFFFFFFFF -> result=0x00000000. MULHU with the same operands -> 0xFFFFFFFE. MULHSU with the same operands -> 0xFFFFFFFF.
3. DIV a=0xFFFFFFEC (-20) b=3 -> 0xFFFFFFFA (-6). REM with the same operands -> 0xFFFFFFFE (-2). DIVU a=20 b=3 -> 6. REMU -> 2.
4. DIVU a=20 b=0 -> done one cycle after acceptance, result=0xFFFFFFFF. REMU -> 20. DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000 after 1 cycle. REM with the same operands -> 0.
5. During a MUL, pulse start with different operands at cycle 10 -> ignored; original product returned. Assert start in the done cycle -> not accepted; re-assert next cycle -> accepted.
6. Assert reset at cycle 15 of a DIV -> next cycle busy=0, done=0, result=0, no done pulse ever. A new MUL 3*5 afterwards returns 15 with normal latency.
